// File: rtl/count_pkg.sv
// Shared definitions for the counter stream producer and its checker.
package count_pkg;

    localparam int unsigned COUNT_W = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAcq   = 2'd1,
        StTrack = 2'd2
    } chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] One = 1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + One;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_checker.sv
// Receiver-side checker: each accepted sample must be the previous one plus 1 (mod 2^WIDTH).
module count_checker
    import count_pkg::*;
#(
    parameter int unsigned WIDTH     = COUNT_W,
    parameter int unsigned ERR_W     = 16,
    parameter int unsigned SMP_W     = 32,
    parameter int unsigned LOCK_LOSS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_count_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [SMP_W-1:0] sample_count_o,
    output logic             first_err_valid_o,
    output logic [WIDTH-1:0] first_err_exp_o,
    output logic [WIDTH-1:0] first_err_got_o
);

    localparam logic [WIDTH-1:0] One      = 1;
    localparam logic [SMP_W-1:0] SmpOne   = 1;
    localparam logic [7:0]       LossCnt  = 8'(LOCK_LOSS);

    chk_state_e       state_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [WIDTH-1:0] exp_q;
    logic [7:0]       miss_q;
    logic [SMP_W-1:0] sample_q;
    logic             fev_q;
    logic [WIDTH-1:0] fexp_q, fgot_q;

    logic       mismatch, track_hit, count_fire, err_inc;
    logic [7:0] miss_next;

    always_comb begin
        mismatch   = (in_count_i != exp_q);
        track_hit  = enable_i && in_valid_i && (state_q == StTrack);
        count_fire = enable_i && in_valid_i && (state_q != StIdle);
        err_inc    = track_hit && mismatch && !clear_i;
        miss_next  = miss_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            exp_q       <= '0;
            miss_q      <= '0;
            sample_q    <= '0;
            fev_q       <= 1'b0;
            fexp_q      <= '0;
            fgot_q      <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (!enable_i) begin
                state_q  <= StIdle;
                locked_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StAcq;
                    end
                    StAcq: begin
                        if (in_valid_i) begin
                            exp_q    <= in_count_i + One;
                            miss_q   <= '0;
                            state_q  <= StTrack;
                            locked_q <= 1'b1;
                        end
                    end
                    StTrack: begin
                        if (in_valid_i) begin
                            if (!mismatch) begin
                                exp_q  <= exp_q + One;
                                miss_q <= '0;
                            end else begin
                                // Re-seed on the received value so one glitch costs one error.
                                err_pulse_q <= 1'b1;
                                exp_q       <= in_count_i + One;
                                miss_q      <= miss_next;
                                if (miss_next >= LossCnt) begin
                                    state_q  <= StAcq;
                                    locked_q <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        locked_q <= 1'b0;
                    end
                endcase
            end

            if (clear_i) begin
                sample_q <= '0;
                fev_q    <= 1'b0;
                fexp_q   <= '0;
                fgot_q   <= '0;
            end else if (count_fire) begin
                sample_q <= sample_q + SmpOne;
                if (err_inc && !fev_q) begin
                    fev_q  <= 1'b1;
                    fexp_q <= exp_q;
                    fgot_q <= in_count_i;
                end
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (err_inc),
        .clr_i  (clear_i),
        .count_o(err_count_o)
    );

    assign locked_o          = locked_q;
    assign err_pulse_o       = err_pulse_q;
    assign sample_count_o    = sample_q;
    assign first_err_valid_o = fev_q;
    assign first_err_exp_o   = fexp_q;
    assign first_err_got_o   = fgot_q;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed vector table, hand sequences and random stimulus vs a model.
module tb_count_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_count = 8'd0;

    logic        locked, err_pulse, fev;
    logic [15:0] err_count;
    logic [31:0] sample_count;
    logic [7:0]  fexp, fgot;

    logic        locked2, err_pulse2, fev2;
    logic [1:0]  err_count2;
    logic [31:0] sample_count2;
    logic [7:0]  fexp2, fgot2;

    always #5 clk = ~clk;

    count_checker #(
        .WIDTH(8), .ERR_W(16), .SMP_W(32), .LOCK_LOSS(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .in_valid_i(in_valid), .in_count_i(in_count),
        .locked_o(locked), .err_pulse_o(err_pulse), .err_count_o(err_count),
        .sample_count_o(sample_count), .first_err_valid_o(fev),
        .first_err_exp_o(fexp), .first_err_got_o(fgot)
    );

    count_checker #(
        .WIDTH(8), .ERR_W(2), .SMP_W(32), .LOCK_LOSS(4)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .in_valid_i(in_valid), .in_count_i(in_count),
        .locked_o(locked2), .err_pulse_o(err_pulse2), .err_count_o(err_count2),
        .sample_count_o(sample_count2), .first_err_valid_o(fev2),
        .first_err_exp_o(fexp2), .first_err_got_o(fgot2)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural reference: mode 0 idle, 1 acquiring, 2 tracking.
    int          m_mode;
    int          m_exp;
    int          m_run;
    logic        m_pulse;
    int          m_errs;
    logic [31:0] m_samp;
    logic        m_fv;
    int          m_fexp, m_fgot;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step(input logic r, input logic en, input logic clr, input logic v,
                              input int cnt);
        if (r) begin
            m_mode = 0; m_exp = 0; m_run = 0; m_pulse = 0; m_errs = 0;
            m_samp = 0; m_fv = 0; m_fexp = 0; m_fgot = 0;
            return;
        end
        m_pulse = 0;
        if (!en) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (v) begin
            if (!clr) m_samp = m_samp + 1;
            if (m_mode == 1) begin
                m_exp = (cnt + 1) % 256;
                m_run = 0;
                m_mode = 2;
            end else if (cnt == m_exp) begin
                m_exp = (m_exp + 1) % 256;
                m_run = 0;
            end else begin
                m_pulse = 1;
                if (!clr) begin
                    m_errs++;
                    if (!m_fv) begin
                        m_fv = 1; m_fexp = m_exp; m_fgot = cnt;
                    end
                end
                m_exp = (cnt + 1) % 256;
                m_run++;
                if (m_run >= 4) m_mode = 1;
            end
        end
        if (clr) begin
            m_errs = 0; m_samp = 0; m_fv = 0; m_fexp = 0; m_fgot = 0;
        end
    endtask

    task automatic compare_model();
        chk("locked", 32'(locked), 32'(m_mode == 2));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("err_count", 32'(err_count), 32'(sat(m_errs, 65535)));
        chk("sample_count", sample_count, m_samp);
        chk("first_err_valid", 32'(fev), 32'(m_fv));
        chk("first_err_exp", 32'(fexp), 32'(m_fexp));
        chk("first_err_got", 32'(fgot), 32'(m_fgot));
        chk("sat_locked", 32'(locked2), 32'(m_mode == 2));
        chk("sat_err_count", 32'(err_count2), 32'(sat(m_errs, 3)));
        chk("sat_sample_count", sample_count2, m_samp);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check 1 time unit later.
    task automatic step(input logic r, input logic en, input logic clr, input logic v,
                        input int cnt);
        rst = r; enable = en; clear = clr; in_valid = v; in_count = 8'(cnt);
        @(posedge clk);
        model_step(r, en, clr, v, cnt);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic en, clr, v;
        int   cnt;
        logic locked, pulse;
        int   errs, samp;
        logic fv;
        int   fexp, fgot;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic clr, input logic v, input int cnt,
                                input logic lk, input logic pl, input int errs, input int samp,
                                input logic fv_i, input int fe, input int fg);
        vec_t t;
        t.en = en; t.clr = clr; t.v = v; t.cnt = cnt; t.locked = lk; t.pulse = pl;
        t.errs = errs; t.samp = samp; t.fv = fv_i; t.fexp = fe; t.fgot = fg;
        return t;
    endfunction

    initial begin
        // Clean stream across the 255->0 wrap, then a single glitch, lock loss, clear+mismatch.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 1, (250 + i) % 256, 1, 0, 0, i + 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 10, 1, 0, 0, 17, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 11, 1, 0, 0, 18, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 12, 1, 0, 0, 19, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 40, 1, 1, 1, 20, 1, 13, 40));
        tbl.push_back(mk(1, 0, 1, 41, 1, 0, 1, 21, 1, 13, 40));
        tbl.push_back(mk(1, 0, 1, 42, 1, 0, 1, 22, 1, 13, 40));
        tbl.push_back(mk(1, 0, 1, 5, 1, 1, 2, 23, 1, 13, 40));
        tbl.push_back(mk(1, 0, 1, 5, 1, 1, 3, 24, 1, 13, 40));
        tbl.push_back(mk(1, 0, 1, 5, 1, 1, 4, 25, 1, 13, 40));
        tbl.push_back(mk(1, 0, 1, 5, 0, 1, 5, 26, 1, 13, 40));
        tbl.push_back(mk(1, 0, 1, 7, 1, 0, 5, 27, 1, 13, 40));
        tbl.push_back(mk(1, 0, 1, 8, 1, 0, 5, 28, 1, 13, 40));
        tbl.push_back(mk(1, 1, 1, 20, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // Reset with enable low and in_valid toggling: everything stays zero.
        step(1, 0, 0, 1, 3);
        step(1, 0, 0, 0, 4);
        step(0, 0, 0, 1, 5);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_sample_count", sample_count, 32'd0);
        chk("rst_first_err_valid", 32'(fev), 32'd0);

        foreach (tbl[i]) begin
            step(0, tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].cnt);
            chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].locked));
            chk($sformatf("vec%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].pulse));
            chk($sformatf("vec%0d_errs", i), 32'(err_count), 32'(tbl[i].errs));
            chk($sformatf("vec%0d_sat_errs", i), 32'(err_count2), 32'(sat(tbl[i].errs, 3)));
            chk($sformatf("vec%0d_samp", i), sample_count, 32'(tbl[i].samp));
            chk($sformatf("vec%0d_fv", i), 32'(fev), 32'(tbl[i].fv));
            chk($sformatf("vec%0d_fexp", i), 32'(fexp), 32'(tbl[i].fexp));
            chk($sformatf("vec%0d_fgot", i), 32'(fgot), 32'(tbl[i].fgot));
        end

        // Saturation with isolated mismatches, then enable drop and re-enable.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 100); step(0, 1, 0, 1, 101);
        step(0, 1, 0, 1, 200); step(0, 1, 0, 1, 201);
        step(0, 1, 0, 1, 50);  step(0, 1, 0, 1, 51);
        step(0, 1, 0, 1, 10);  step(0, 1, 0, 1, 11);
        step(0, 1, 0, 1, 90);
        chk("sat_hold_narrow", 32'(err_count2), 32'd3);
        chk("sat_wide_count", 32'(err_count), 32'd5);
        chk("sat_still_locked", 32'(locked), 32'd1);
        step(0, 0, 0, 1, 91);
        chk("disable_unlocks", 32'(locked), 32'd0);
        chk("disable_keeps_samples", sample_count, 32'd10);
        chk("disable_keeps_errs", 32'(err_count2), 32'd3);
        step(0, 1, 0, 1, 92);
        chk("reenable_acq", 32'(locked), 32'd0);
        chk("reenable_no_count", sample_count, 32'd10);
        step(0, 1, 0, 1, 30);
        chk("reenable_track", 32'(locked), 32'd1);
        chk("reenable_count", sample_count, 32'd11);

        // Random traffic, mostly in-sequence values with occasional glitches and controls.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            logic r, en, clr, v;
            int cnt;
            r   = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 59) != 0);
            clr = ($urandom_range(0, 79) == 0);
            v   = ($urandom_range(0, 3) != 0);
            cnt = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 255));
            step(r, en, clr, v, cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
